// File: rtl/microc_pkg.sv
// microc_pkg
// Shared definitions for the microc control path: opcode field constants
// (upper four opcode bits), ALU operation codes, FSM state encoding and the
// control-word structure produced by the decoder.
package microc_pkg;

    // Opcode[5:2] values for the non-ALU instructions. Opcode[5]=1 marks an
    // ALU instruction, where Opcode[4:2] is the ALU operation and Opcode[1]
    // selects the immediate operand.
    localparam logic [3:0] OP_LI   = 4'b0000;
    localparam logic [3:0] OP_J    = 4'b0001;
    localparam logic [3:0] OP_JZ   = 4'b0010;
    localparam logic [3:0] OP_JNZ  = 4'b0011;
    localparam logic [3:0] OP_NOP  = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b0101;
    localparam logic [3:0] OP_ILL0 = 4'b0110;
    localparam logic [3:0] OP_ILL1 = 4'b0111;

    localparam int ALU_OP_W = 3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    typedef struct packed {
        logic                s_inc;
        logic                s_inm;
        logic                we;
        logic                wez;
        logic [ALU_OP_W-1:0] alu_op;
        logic                pc_en;
    } ctrl_t;

    // Control word driven whenever no instruction executes.
    localparam ctrl_t CTRL_INACTIVE = '{
        s_inc:  1'b1,
        s_inm:  1'b0,
        we:     1'b0,
        wez:    1'b0,
        alu_op: ALU_OP_DEFAULT,
        pc_en:  1'b0
    };

    function automatic logic is_alu_op(input logic [5:0] opcode);
        return opcode[5];
    endfunction

endpackage

// File: rtl/unidad_control_decodificador.sv
// decodificador
// Purely combinational decode of the current opcode and registered zero flag
// into a control word. The word assumes the instruction executes; gating by
// the FSM happens in unidad_control.
// Ports:
//   opcode   in  6  current instruction opcode
//   z        in  1  registered zero flag
//   ctrl     out    decoded control word (ctrl_t)
//   illegal  out 1  opcode is in the reserved 0110xx/0111xx range
//   is_halt  out 1  opcode is HALT (0101xx)
module decodificador
    import microc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       is_halt
);

    // Opcode[0] is a don't-care for every instruction class.
    logic unused_opcode_lsb;
    assign unused_opcode_lsb = opcode[0];

    always_comb begin
        ctrl        = CTRL_INACTIVE;
        ctrl.pc_en  = 1'b1;
        illegal     = 1'b0;
        is_halt     = 1'b0;

        if (is_alu_op(opcode)) begin
            ctrl.we     = 1'b1;
            ctrl.wez    = 1'b1;
            ctrl.s_inm  = opcode[1];
            ctrl.alu_op = opcode[4:2];
        end else begin
            unique case (opcode[5:2])
                OP_LI: begin
                    ctrl.we    = 1'b1;
                    ctrl.s_inm = 1'b1;
                end
                OP_J:    ctrl.s_inc = 1'b0;
                // Branches look at the flag from the previous instruction.
                OP_JZ:   ctrl.s_inc = ~z;
                OP_JNZ:  ctrl.s_inc = z;
                OP_NOP:  ;
                OP_HALT: begin
                    ctrl.pc_en = 1'b0;
                    is_halt    = 1'b1;
                end
                OP_ILL0, OP_ILL1: illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/unidad_control.sv
// unidad_control
// Sequenced control unit for the microc single-cycle datapath. Holds the
// IDLE/RUN/HALT state machine, single-step gating, the sticky illegal-opcode
// flag and the retired-instruction counter. Control outputs are combinational
// so that the single-cycle datapath sees them in the exec cycle itself.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   start                 leaves IDLE
//   step_mode, step       single-step control
//   Opcode, z             instruction opcode and registered zero flag
//   s_inc, s_inm, we, wez, ALUOp, pc_en   datapath control (combinational)
//   halted                registered, high in HALT
//   illegal               sticky illegal-opcode flag
//   icount                retired-instruction count (wraps)
module unidad_control
    import microc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    state_t state;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;
    logic   dec_illegal;
    logic   dec_halt;
    logic   exec;

    decodificador u_decodificador (
        .opcode  (Opcode),
        .z       (z),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .is_halt (dec_halt)
    );

    // step_mode is not registered so toggling it affects the current cycle.
    assign exec = (state == ST_RUN) && (!step_mode || step);

    always_comb begin
        ctrl = CTRL_INACTIVE;
        if (exec) begin
            ctrl = dec_ctrl;
        end
    end

    assign s_inc = ctrl.s_inc;
    assign s_inm = ctrl.s_inm;
    assign we    = ctrl.we;
    assign wez   = ctrl.wez;
    assign ALUOp = ctrl.alu_op;
    assign pc_en = ctrl.pc_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            halted  <= 1'b0;
            illegal <= 1'b0;
            icount  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (exec && dec_halt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: ;
                default: begin
                    state  <= ST_IDLE;
                    halted <= 1'b0;
                end
            endcase

            if (exec) begin
                icount <= icount + CNT_W'(1);
                if (dec_illegal) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

endmodule
